// File: rtl/vt52_esc_parser.sv
// VT52 escape-sequence parser: turns a byte stream into cursor/erase/print commands.
// Latency: cmd_valid rises on the clock edge that accepts the final byte of a command.
// Backpressure: while a command waits for cmd_ready, in_ready stays low (one command in flight).
//
// Ports:
//   clk, clr                 clock and asynchronous active-high reset
//   in_data/in_valid/in_ready   byte stream from the UART pipeline (valid/ready)
//   cmd_valid/cmd_ready      decoded command handshake
//   cmd_code                 0 PRINT,1 CR,2 LF,3 BS,4 TAB,5 UP,6 DOWN,7 RIGHT,8 LEFT,
//                            9 HOME,10 ERASE_EOS,11 ERASE_EOL,12 GOTO,13 RLF,14 IDENT
//   cmd_char                 printable character (PRINT only)
//   cmd_row / cmd_col        clamped cursor target (GOTO only)
// Build option: define VT52_IDENT_EN to decode ESC 'Z' as IDENT (code 14).
module vt52_esc_parser #(
    parameter int ROWS     = 24,
    parameter int COLS     = 80,
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 7
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [3:0]          cmd_code,
    output logic [7:0]          cmd_char,
    output logic [ROW_BITS-1:0] cmd_row,
    output logic [COL_BITS-1:0] cmd_col
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ESC   = 3'd1,
        S_Y_ROW = 3'd2,
        S_Y_COL = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] C_PRINT     = 4'd0;
    localparam logic [3:0] C_CR        = 4'd1;
    localparam logic [3:0] C_LF        = 4'd2;
    localparam logic [3:0] C_BS        = 4'd3;
    localparam logic [3:0] C_TAB       = 4'd4;
    localparam logic [3:0] C_UP        = 4'd5;
    localparam logic [3:0] C_DOWN      = 4'd6;
    localparam logic [3:0] C_RIGHT     = 4'd7;
    localparam logic [3:0] C_LEFT      = 4'd8;
    localparam logic [3:0] C_HOME      = 4'd9;
    localparam logic [3:0] C_ERASE_EOS = 4'd10;
    localparam logic [3:0] C_ERASE_EOL = 4'd11;
    localparam logic [3:0] C_GOTO      = 4'd12;
    localparam logic [3:0] C_RLF       = 4'd13;
`ifdef VT52_IDENT_EN
    localparam logic [3:0] C_IDENT     = 4'd14;
`endif

    localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);
    localparam logic [7:0] COL_MAX = 8'(COLS - 1);

    state_t                state_q,     state_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic [3:0]            cmd_code_q,  cmd_code_d;
    logic [7:0]            cmd_char_q,  cmd_char_d;
    logic [ROW_BITS-1:0]   cmd_row_q,   cmd_row_d;
    logic [COL_BITS-1:0]   cmd_col_q,   cmd_col_d;
    // Row captured from the first GOTO argument, held until the column arrives.
    logic [ROW_BITS-1:0]   srow_q,      srow_d;

    logic                  accept;
    logic                  emit;
    logic [3:0]            emit_code;
    logic                  is_abort;
    logic                  is_print;
    logic [7:0]            coord_off;
    logic [7:0]            row_val;
    logic [7:0]            col_val;

    // No byte is taken while a command is pending or while reset is held.
    assign in_ready = (state_q != S_HOLD) && !clr;
    assign accept   = in_valid && in_ready;

    assign is_abort = (in_data == 8'h18) || (in_data == 8'h1A);
    assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);

    // GOTO coordinates are offset by 0x20 and clamped to the screen in both directions.
    assign coord_off = in_data - 8'h20;

    always_comb begin
        row_val = 8'h00;
        col_val = 8'h00;
        if (in_data >= 8'h20) begin
            row_val = (coord_off > ROW_MAX) ? ROW_MAX : coord_off;
            col_val = (coord_off > COL_MAX) ? COL_MAX : coord_off;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        cmd_char_d  = cmd_char_q;
        cmd_row_d   = cmd_row_q;
        cmd_col_d   = cmd_col_q;
        srow_d      = srow_q;
        emit        = 1'b0;
        emit_code   = C_PRINT;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        emit       = 1'b1;
                        emit_code  = C_PRINT;
                        cmd_char_d = in_data;
                    end else begin
                        case (in_data)
                            8'h0D: begin emit = 1'b1; emit_code = C_CR;  end
                            8'h0A: begin emit = 1'b1; emit_code = C_LF;  end
                            8'h08: begin emit = 1'b1; emit_code = C_BS;  end
                            8'h09: begin emit = 1'b1; emit_code = C_TAB; end
                            8'h1B: state_d = S_ESC;
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end

            S_ESC: begin
                if (accept) begin
                    // Unknown bytes (including CAN/SUB) fall back to IDLE silently.
                    state_d = S_IDLE;
                    case (in_data)
                        8'h41: begin emit = 1'b1; emit_code = C_UP;        end
                        8'h42: begin emit = 1'b1; emit_code = C_DOWN;      end
                        8'h43: begin emit = 1'b1; emit_code = C_RIGHT;     end
                        8'h44: begin emit = 1'b1; emit_code = C_LEFT;      end
                        8'h48: begin emit = 1'b1; emit_code = C_HOME;      end
                        8'h4A: begin emit = 1'b1; emit_code = C_ERASE_EOS; end
                        8'h4B: begin emit = 1'b1; emit_code = C_ERASE_EOL; end
                        8'h49: begin emit = 1'b1; emit_code = C_RLF;       end
`ifdef VT52_IDENT_EN
                        8'h5A: begin emit = 1'b1; emit_code = C_IDENT;     end
`endif
                        8'h59: state_d = S_Y_ROW;
                        // A repeated ESC restarts the escape sequence.
                        8'h1B: state_d = S_ESC;
                        default: state_d = S_IDLE;
                    endcase
                end
            end

            S_Y_ROW: begin
                if (accept) begin
                    if (is_abort) begin
                        state_d = S_IDLE;
                    end else begin
                        srow_d  = ROW_BITS'(row_val);
                        state_d = S_Y_COL;
                    end
                end
            end

            S_Y_COL: begin
                if (accept) begin
                    if (is_abort) begin
                        state_d = S_IDLE;
                    end else begin
                        emit      = 1'b1;
                        emit_code = C_GOTO;
                        cmd_row_d = srow_q;
                        cmd_col_d = COL_BITS'(col_val);
                    end
                end
            end

            S_HOLD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                cmd_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        if (emit) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = emit_code;
            state_d     = S_HOLD;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 4'd0;
            cmd_char_q  <= 8'h00;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            srow_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_char_q  <= cmd_char_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            srow_q      <= srow_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_char  = cmd_char_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;

endmodule

// File: tb/tb_vt52_esc_parser.sv
// Testbench for vt52_esc_parser: table of byte sequences with expected commands,
// plus hand-written sequences for latency, backpressure and mid-sequence reset.
// Expected commands go into a queue when driven and are checked as the DUT hands them off.
module tb_vt52_esc_parser;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_code;
    logic [7:0] cmd_char;
    logic [4:0] cmd_row;
    logic [6:0] cmd_col;

    int checks = 0;
    int errors = 0;

    vt52_esc_parser #(.ROWS(24), .COLS(80), .ROW_BITS(5), .COL_BITS(7)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_char  (cmd_char),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int ch;
        int row;
        int col;
    } exp_t;

    typedef struct {
        logic [3:0][7:0] b;   // b[3] is sent first
        int              n;
        logic            exp;
        int              code;
        int              ch;
        int              row;
        int              col;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    exp_t got;

    // Reference copy of the data fields; they only change on PRINT/GOTO.
    int m_char = 0;
    int m_row  = 0;
    int m_col  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_cmd(input int code, input int ch, input int row, input int col);
        exp_t e;
        if (code == 0) m_char = ch;
        if (code == 12) begin
            m_row = row;
            m_col = col;
        end
        e.code = code;
        e.ch   = m_char;
        e.row  = m_row;
        e.col  = m_col;
        exp_q.push_back(e);
    endtask

    function automatic vec_t mk(input logic [31:0] b, input int n, input logic e,
                                input int code, input int ch, input int row, input int col);
        vec_t v;
        v.b = b; v.n = n; v.exp = e;
        v.code = code; v.ch = ch; v.row = row; v.col = col;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (4) @(negedge clk);
        chk(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handed-off command must match the oldest expectation.
    always @(negedge clk) begin
        if (!clr && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got code %0d expected no command", cmd_code);
            end else begin
                got = exp_q.pop_front();
                chk("cmd_code", int'(cmd_code), got.code);
                chk("cmd_char", int'(cmd_char), got.ch);
                chk("cmd_row",  int'(cmd_row),  got.row);
                chk("cmd_col",  int'(cmd_col),  got.col);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        cmd_ready = 1'b1;

        vecs.push_back(mk(32'h48000000, 1, 1, 0, 8'h48, 0, 0));
        vecs.push_back(mk(32'h69000000, 1, 1, 0, 8'h69, 0, 0));
        vecs.push_back(mk(32'h20000000, 1, 1, 0, 8'h20, 0, 0));
        vecs.push_back(mk(32'h7E000000, 1, 1, 0, 8'h7E, 0, 0));
        vecs.push_back(mk(32'h0D000000, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0A000000, 1, 1, 2, 0, 0, 0));
        vecs.push_back(mk(32'h08000000, 1, 1, 3, 0, 0, 0));
        vecs.push_back(mk(32'h09000000, 1, 1, 4, 0, 0, 0));
        vecs.push_back(mk(32'h01000000, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h7F000000, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h18000000, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h1B410000, 2, 1, 5, 0, 0, 0));
        vecs.push_back(mk(32'h1B420000, 2, 1, 6, 0, 0, 0));
        vecs.push_back(mk(32'h1B430000, 2, 1, 7, 0, 0, 0));
        vecs.push_back(mk(32'h1B440000, 2, 1, 8, 0, 0, 0));
        vecs.push_back(mk(32'h1B480000, 2, 1, 9, 0, 0, 0));
        vecs.push_back(mk(32'h1B4A0000, 2, 1, 10, 0, 0, 0));
        vecs.push_back(mk(32'h1B4B0000, 2, 1, 11, 0, 0, 0));
        vecs.push_back(mk(32'h1B490000, 2, 1, 13, 0, 0, 0));
        vecs.push_back(mk(32'h1B1B4100, 3, 1, 5, 0, 0, 0));
        vecs.push_back(mk(32'h1B592530, 4, 1, 12, 0, 5, 16));
        vecs.push_back(mk(32'h1B597F7F, 4, 1, 12, 0, 23, 79));
        vecs.push_back(mk(32'h1B591010, 4, 1, 12, 0, 0, 0));
        vecs.push_back(mk(32'h1B593736, 4, 1, 12, 0, 23, 22));
        vecs.push_back(mk(32'h1B591851, 4, 1, 0, 8'h51, 0, 0));
        vecs.push_back(mk(32'h1B712100, 3, 1, 0, 8'h21, 0, 0));
        vecs.push_back(mk(32'h1B591A00, 3, 0, 0, 0, 0, 0));
`ifdef VT52_IDENT_EN
        vecs.push_back(mk(32'h1B5A0000, 2, 1, 14, 0, 0, 0));
`else
        vecs.push_back(mk(32'h1B5A0000, 2, 0, 0, 0, 0, 0));
`endif

        // Reset state while clr is held.
        @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  0);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_cmd_code",  int'(cmd_code),  0);
        chk("rst_cmd_char",  int'(cmd_char),  0);
        chk("rst_cmd_row",   int'(cmd_row),   0);
        chk("rst_cmd_col",   int'(cmd_col),   0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;

        // 'H','i' back to back: one-cycle latency, in_ready low while holding.
        push_cmd(0, 8'h48, 0, 0);
        push_cmd(0, 8'h69, 0, 0);
        send_byte(8'h48);
        @(negedge clk);
        chk("lat_H_valid", int'(cmd_valid), 1);
        chk("lat_H_rdy",   int'(in_ready),  0);
        @(posedge clk);
        #1;
        send_byte(8'h69);
        @(negedge clk);
        chk("lat_i_valid", int'(cmd_valid), 1);
        @(posedge clk);
        #1;
        drain("drain_hi");

        // Table vectors.
        foreach (vecs[i]) begin
            if (vecs[i].exp)
                push_cmd(vecs[i].code, vecs[i].ch, vecs[i].row, vecs[i].col);
            for (int j = 0; j < vecs[i].n; j++)
                send_byte(vecs[i].b[3 - j]);
            drain("drain_vec");
        end

        // Backpressure: UP held for 10 cycles, 'x' waits until consumption.
        cmd_ready = 1'b0;
        push_cmd(5, 0, 0, 0);
        send_byte(8'h1B);
        send_byte(8'h41);
        in_data  = 8'h78;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", int'(cmd_valid), 1);
            chk("bp_code",  int'(cmd_code),  5);
            chk("bp_rdy",   int'(in_ready),  0);
        end
        push_cmd(0, 8'h78, 0, 0);
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        @(negedge clk);
        chk("bp_consume_rdy", int'(in_ready), 0);
        @(negedge clk);
        chk("bp_after_valid", int'(cmd_valid), 0);
        chk("bp_after_rdy",   int'(in_ready),  1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("drain_bp");

        // Mid-sequence reset discards the pending GOTO.
        send_byte(8'h1B);
        send_byte(8'h59);
        send_byte(8'h25);
        #3;
        clr = 1'b1;
        #1;
        chk("mid_rst_rdy",   int'(in_ready),  0);
        chk("mid_rst_valid", int'(cmd_valid), 0);
        m_char = 0;
        m_row  = 0;
        m_col  = 0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        push_cmd(0, 8'h30, 0, 0);
        send_byte(8'h30);
        drain("drain_rst");

        chk("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
